// File: rtl/pp_accum_batch.sv
// Batch accumulator behind the partial-product align stage: sign-extends each aligned
// product, sums BATCH of them and emits the total with its Q_frac tag and a mismatch flag.

module ADD #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic [50:0]  number
);
    assign sum    = a + b;
    assign number = 51'(W);
endmodule

module MX #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] y,
    output logic [50:0]  number
);
    assign y      = sel ? b : a;
    assign number = 51'(W);
endmodule

module EQ #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic [50:0]  number
);
    assign eq     = (a == b);
    assign number = 51'(W);
endmodule

module pp_accum_batch #(
    parameter int BATCH = 8,
    parameter int PP_W  = 15,
    parameter int ACC_W = 18
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [PP_W-1:0]  i_align_pp,
    input  logic [4:0]       i_Q_frac,
    input  logic             i_flush,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_valid,
    output logic [4:0]       o_Q_frac,
    output logic             o_q_mismatch,
    output logic             o_busy,
    output logic [50:0]      number
);
    localparam int CW = $clog2(BATCH);
    localparam logic [CW-1:0] LAST_CNT = CW'(BATCH - 1);
    localparam logic [CW-1:0] ZERO_CNT = '0;

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [CW-1:0]    cnt, cnt_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [4:0]       q_ref, q_ref_next;
    logic             mism, mism_next;
    logic             valid_next, load_out;
    logic             cnt_zero, cnt_last, q_eq, mism_out;
    logic [ACC_W-1:0] ext, add_a, add_sum;
    logic [50:0]      n_add, n_mx, n_eq_q, n_eq_z, n_eq_l;
    state_t           state;

    assign ext = {{(ACC_W-PP_W){i_align_pp[PP_W-1]}}, i_align_pp};

    // First product of a batch adds onto zero, so one adder serves both paths.
    MX  #(.W(ACC_W)) u_mx_a   (.a(acc), .b('0), .sel(cnt_zero), .y(add_a), .number(n_mx));
    ADD #(.W(ACC_W)) u_add    (.a(add_a), .b(ext), .sum(add_sum), .number(n_add));
    EQ  #(.W(5))     u_eq_q   (.a(i_Q_frac), .b(q_ref), .eq(q_eq), .number(n_eq_q));
    EQ  #(.W(CW))    u_eq_z   (.a(cnt), .b(ZERO_CNT), .eq(cnt_zero), .number(n_eq_z));
    EQ  #(.W(CW))    u_eq_l   (.a(cnt), .b(LAST_CNT), .eq(cnt_last), .number(n_eq_l));

    assign number   = n_mx + n_add + n_eq_q + n_eq_z + n_eq_l;
    assign state    = cnt_zero ? IDLE : ACCUM;
    assign o_busy   = (state == ACCUM);
    assign mism_out = mism | ~q_eq;

    always_comb begin
        cnt_next   = cnt;
        acc_next   = acc;
        q_ref_next = q_ref;
        mism_next  = mism;
        valid_next = 1'b0;
        load_out   = 1'b0;
        if (i_flush) begin
            cnt_next  = '0;
            acc_next  = '0;
            mism_next = 1'b0;
        end else if (i_valid) begin
            case (state)
                IDLE: begin
                    acc_next   = add_sum;
                    q_ref_next = i_Q_frac;
                    mism_next  = 1'b0;
                    cnt_next   = CW'(1);
                end
                ACCUM: begin
                    if (cnt_last) begin
                        load_out   = 1'b1;
                        valid_next = 1'b1;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end else begin
                        acc_next  = add_sum;
                        mism_next = mism_out;
                        cnt_next  = cnt + CW'(1);
                    end
                end
                default: cnt_next = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt          <= '0;
            acc          <= '0;
            q_ref        <= '0;
            mism         <= 1'b0;
            o_valid      <= 1'b0;
            o_sum        <= '0;
            o_Q_frac     <= '0;
            o_q_mismatch <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            acc     <= acc_next;
            q_ref   <= q_ref_next;
            mism    <= mism_next;
            o_valid <= valid_next;
            if (load_out) begin
                o_sum        <= add_sum;
                o_Q_frac     <= q_ref;
                o_q_mismatch <= mism_out;
            end
        end
    end
endmodule

// File: tb/tb_pp_accum_batch.sv
// Scoreboard bench for pp_accum_batch: an integer model queues each completed batch,
// and a negedge monitor pops and compares on every o_valid pulse.

module tb_pp_accum_batch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [14:0] pp = '0;
    logic [4:0]  qf = '0;
    logic [17:0] o_sum;
    logic        o_valid;
    logic [4:0]  o_Q_frac;
    logic        o_q_mismatch;
    logic        o_busy;
    logic [50:0] number;

    typedef struct {
        logic [17:0] sum;
        logic [4:0]  qf;
        logic        mism;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail = 0;
    int n_pulses = 0;

    int          m_cnt = 0;
    int          m_acc = 0;
    logic [4:0]  m_qref = '0;
    logic        m_mism = 1'b0;
    logic [17:0] l_sum = '0;
    logic [4:0]  l_qf = '0;
    logic        l_mism = 1'b0;

    pp_accum_batch #(.BATCH(8), .PP_W(15), .ACC_W(18)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_valid(valid),
        .i_align_pp(pp),
        .i_Q_frac(qf),
        .i_flush(flush),
        .o_sum(o_sum),
        .o_valid(o_valid),
        .o_Q_frac(o_Q_frac),
        .o_q_mismatch(o_q_mismatch),
        .o_busy(o_busy),
        .number(number)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && o_valid) begin
            n_pulses++;
            if (sb.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_sum", 64'(o_sum), 64'(e.sum));
                check("sb_qfrac", 64'(o_Q_frac), 64'(e.qf));
                check("sb_mism", 64'(o_q_mismatch), 64'(e.mism));
            end
        end
    end

    // Called at posedge+1; drives one cycle and checks the registered outputs after the edge.
    task automatic send(input logic v, input logic [14:0] p, input logic [4:0] q, input logic f);
        bit done;
        int val;
        done  = 1'b0;
        valid = v;
        pp    = p;
        qf    = q;
        flush = f;
        if (f) begin
            m_cnt  = 0;
            m_acc  = 0;
            m_mism = 1'b0;
        end else if (v) begin
            val = p[14] ? int'(p) - 32768 : int'(p);
            if (m_cnt == 0) begin
                m_acc  = val;
                m_qref = q;
                m_mism = 1'b0;
            end else begin
                m_acc = m_acc + val;
                if (q != m_qref) m_mism = 1'b1;
            end
            m_cnt++;
            if (m_cnt == 8) begin
                done   = 1'b1;
                m_cnt  = 0;
                l_sum  = 18'(m_acc);
                l_qf   = m_qref;
                l_mism = m_mism;
                sb.push_back('{l_sum, l_qf, l_mism});
                m_acc  = 0;
            end
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        check("valid_pulse", 64'(o_valid), 64'(done));
        check("busy", 64'(o_busy), 64'(m_cnt != 0));
        check("hold_sum", 64'(o_sum), 64'(l_sum));
        check("hold_qfrac", 64'(o_Q_frac), 64'(l_qf));
        check("hold_mism", 64'(o_q_mismatch), 64'(l_mism));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        valid = 1'b0;
        flush = 1'b0;
        check("rst_sum", 64'(o_sum), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_qfrac", 64'(o_Q_frac), 64'd0);
        check("rst_mism", 64'(o_q_mismatch), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        m_cnt  = 0;
        m_acc  = 0;
        m_mism = 1'b0;
        l_sum  = '0;
        l_qf   = '0;
        l_mism = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 15'h0, 5'd0, 1'b0);
    endtask

    initial begin
        int p0;
        #3;
        do_reset();

        // 1: eight +4096 products
        for (int i = 0; i < 8; i++) send(1'b1, 15'h1000, 5'd10, 1'b0);
        check("t1_sum", 64'(o_sum), 64'h08000);
        check("t1_qfrac", 64'(o_Q_frac), 64'd10);
        check("t1_mism", 64'(o_q_mismatch), 64'd0);
        idle(2);

        // 2: alternating +/-4096, then full-scale-ish negatives
        for (int i = 0; i < 8; i++) send(1'b1, (i % 2 == 0) ? 15'h1000 : 15'h7000, 5'd7, 1'b0);
        check("t2a_sum", 64'(o_sum), 64'h0);
        for (int i = 0; i < 8; i++) send(1'b1, 15'h4001, 5'd7, 1'b0);
        check("t2b_sum", 64'(o_sum), 64'h20008);
        idle(1);

        // 3: gap inside a batch
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) send(1'b1, 15'($urandom), 5'd2, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) send(1'b1, 15'($urandom), 5'd2, 1'b0);
        idle(2);
        check("t3_pulses", 64'(n_pulses - p0), 64'd1);

        // 4: flush with concurrent valid, then clean batch
        p0 = n_pulses;
        for (int i = 0; i < 5; i++) send(1'b1, 15'($urandom), 5'd1, 1'b0);
        send(1'b1, 15'h2222, 5'd1, 1'b1);
        idle(2);
        for (int i = 0; i < 8; i++) send(1'b1, 15'($urandom), 5'd1, 1'b0);
        idle(1);
        check("t4_pulses", 64'(n_pulses - p0), 64'd1);

        // 5: Q_frac mismatch on 4th product, then a clean batch back-to-back
        for (int i = 0; i < 8; i++) send(1'b1, 15'($urandom), (i == 3) ? 5'd4 : 5'd3, 1'b0);
        check("t5a_mism", 64'(o_q_mismatch), 64'd1);
        check("t5a_qfrac", 64'(o_Q_frac), 64'd3);
        for (int i = 0; i < 8; i++) send(1'b1, 15'($urandom), 5'd4, 1'b0);
        check("t5b_mism", 64'(o_q_mismatch), 64'd0);
        idle(1);

        // 6: two back-to-back batches, reset during the third
        p0 = n_pulses;
        for (int i = 0; i < 18; i++) send(1'b1, 15'($urandom), 5'd9, 1'b0);
        check("t6_pulses", 64'(n_pulses - p0), 64'd2);
        valid = 1'b1;
        pp    = 15'h0123;
        qf    = 5'd9;
        #2;
        do_reset();
        idle(10);
        check("t6_no_pulse", 64'(n_pulses - p0), 64'd2);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
